// File: rtl/qed_pkg.sv
// qed_pkg: shared types and defaults for the Symbolic-QED commit tracker.
package qed_pkg;

  // Default width of each commit counter.
  localparam int unsigned CNT_W_DEFAULT = 8;

  // Tracker phases:
  //   S_ORIG - original instructions are retiring
  //   S_DUP  - sif_commit has been seen, duplicates are retiring
  //   S_SAT  - a counter tried to wrap; counts are no longer trustworthy
  typedef enum logic [1:0] {
    S_ORIG = 2'd0,
    S_DUP  = 2'd1,
    S_SAT  = 2'd2
  } qed_state_e;

endpackage : qed_pkg

// File: rtl/qed_sat_counter.sv
// qed_sat_counter: CNT_W-bit commit counter with increment enable and freeze.
// It never wraps. would_ovf flags an increment request made at the maximum
// value, and the owner uses it to move to saturation. The next-state value is
// exported so the owner can register decodes that are aligned with the count.
module qed_sat_counter
  import qed_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             freeze,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic             would_ovf
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_max;
  logic             inc_live;

  assign at_max   = (count_q == '1);
  assign inc_live = inc & ~freeze;

  // Next count: hold when frozen, and refuse to wrap at the maximum value.
  always_comb begin
    count_d   = count_q;
    would_ovf = 1'b0;
    if (inc_live) begin
      if (at_max) begin
        would_ovf = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule : qed_sat_counter

// File: rtl/qed_commit_tracker.sv
// qed_commit_tracker: counts original and duplicate commits of a Symbolic-QED
// run and produces the sif_commit_pulsed / qed_check_valid strobes that the
// consistency checkers use.
//
// Optional feature, selected by the macro QED_STRICT_ORDER_EN: sticky
// commit-ordering check on order_err. With the macro undefined, order_err is
// tied low.
module qed_commit_tracker
  import qed_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sif_commit,
  input  logic             commit_valid,
  input  logic             commit_is_dup,
  output logic             sif_commit_pulsed,
  output logic             qed_check_valid,
  output logic [CNT_W-1:0] orig_count,
  output logic [CNT_W-1:0] dup_count,
  output logic             order_err
);

  qed_state_e       state_q;
  qed_state_e       state_d;
  logic             sif_commit_pulsed_q;
  logic             sif_commit_pulsed_d;
  logic             qed_check_valid_q;
  logic             qed_check_valid_d;
  logic             order_err_q;
  logic             order_err_d;

  logic             inc_orig;
  logic             inc_dup;
  logic             frozen;
  logic             orig_ovf;
  logic             dup_ovf;
  logic             any_ovf;
  logic [CNT_W-1:0] orig_q;
  logic [CNT_W-1:0] dup_q;
  logic [CNT_W-1:0] orig_d;
  logic [CNT_W-1:0] dup_d;

  // The interface carries one commit per cycle, steered by commit_is_dup.
  assign inc_orig = commit_valid & ~commit_is_dup;
  assign inc_dup  = commit_valid &  commit_is_dup;
  assign frozen   = (state_q == S_SAT);

  qed_sat_counter #(
    .CNT_W (CNT_W)
  ) u_orig_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (inc_orig),
    .freeze     (frozen),
    .count      (orig_q),
    .count_next (orig_d),
    .would_ovf  (orig_ovf)
  );

  qed_sat_counter #(
    .CNT_W (CNT_W)
  ) u_dup_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc        (inc_dup),
    .freeze     (frozen),
    .count      (dup_q),
    .count_next (dup_d),
    .would_ovf  (dup_ovf)
  );

  assign any_ovf = orig_ovf | dup_ovf;

  // Phase sequencing. Saturation wins over the sif_commit switch, so a run
  // that overflows in the same cycle sif_commit arrives never pulses.
  always_comb begin
    state_d             = state_q;
    sif_commit_pulsed_d = 1'b0;
    unique case (state_q)
      S_ORIG: begin
        if (any_ovf) begin
          state_d = S_SAT;
        end else if (sif_commit) begin
          state_d             = S_DUP;
          sif_commit_pulsed_d = 1'b1;
        end
      end
      S_DUP: begin
        if (any_ovf) begin
          state_d = S_SAT;
        end
      end
      S_SAT: begin
        state_d = S_SAT;
      end
      default: begin
        state_d = S_ORIG;
      end
    endcase
  end

`ifdef QED_STRICT_ORDER_EN
  logic order_viol;

  // Ordering rules: no duplicates before the switch, no originals after it,
  // and never more duplicates than originals. They are not evaluated once
  // saturated, because the counts are frozen and meaningless from then on.
  always_comb begin
    order_viol = 1'b0;
    if (!frozen) begin
      if (inc_dup && (state_q == S_ORIG)) begin
        order_viol = 1'b1;
      end
      if (inc_orig && (state_q == S_DUP)) begin
        order_viol = 1'b1;
      end
      if (inc_dup && (dup_q >= orig_q)) begin
        order_viol = 1'b1;
      end
    end
    order_err_d = order_err_q | order_viol;
  end
`else
  // No ordering checks: the error flag is constant low.
  always_comb begin
    order_err_d = 1'b0;
  end
`endif

  // The check strobe is decoded from next-state values and then registered.
  // This keeps it cycle-aligned with the counters and leaves no path from an
  // input to the output.
  always_comb begin
    qed_check_valid_d = (state_d == S_DUP) &&
                        (orig_d == dup_d) &&
                        (orig_d != '0) &&
                        !order_err_d;
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= S_ORIG;
      sif_commit_pulsed_q <= 1'b0;
      qed_check_valid_q   <= 1'b0;
      order_err_q         <= 1'b0;
    end else begin
      state_q             <= state_d;
      sif_commit_pulsed_q <= sif_commit_pulsed_d;
      qed_check_valid_q   <= qed_check_valid_d;
      order_err_q         <= order_err_d;
    end
  end

  assign sif_commit_pulsed = sif_commit_pulsed_q;
  assign qed_check_valid   = qed_check_valid_q;
  assign orig_count        = orig_q;
  assign dup_count         = dup_q;
  assign order_err         = order_err_q;

endmodule : qed_commit_tracker

// File: tb/tb_qed_commit_tracker.sv
// tb_qed_commit_tracker: directed plus randomized bench for qed_commit_tracker.
// Two instances (CNT_W=8 and CNT_W=2) share one stimulus stream. Each instance
// is checked every cycle against a count-level reference model.
module tb_qed_commit_tracker;

`ifdef QED_STRICT_ORDER_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sif_commit = 1'b0;
  logic       commit_valid = 1'b0;
  logic       commit_is_dup = 1'b0;

  logic       p8, q8, e8;
  logic [7:0] o8, d8;
  logic       p2, q2, e2;
  logic [1:0] o2, d2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: phase 0 = before switch, 1 = after switch, 2 = saturated
  int m_orig [2];
  int m_dup  [2];
  int m_phase[2];
  bit m_pulse[2];
  bit m_err  [2];
  int m_max  [2] = '{255, 3};

  always #5 clk = ~clk;

  qed_commit_tracker #(.CNT_W(8)) dut8 (
    .clk               (clk),
    .rst_n             (rst_n),
    .sif_commit        (sif_commit),
    .commit_valid      (commit_valid),
    .commit_is_dup     (commit_is_dup),
    .sif_commit_pulsed (p8),
    .qed_check_valid   (q8),
    .orig_count        (o8),
    .dup_count         (d8),
    .order_err         (e8)
  );

  qed_commit_tracker #(.CNT_W(2)) dut2 (
    .clk               (clk),
    .rst_n             (rst_n),
    .sif_commit        (sif_commit),
    .commit_valid      (commit_valid),
    .commit_is_dup     (commit_is_dup),
    .sif_commit_pulsed (p2),
    .qed_check_valid   (q2),
    .orig_count        (o2),
    .dup_count         (d2),
    .order_err         (e2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_qcv(input int i);
    return (m_phase[i] == 1) && (m_orig[i] == m_dup[i]) && (m_orig[i] != 0) && !m_err[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_orig[i]  = 0;
      m_dup[i]   = 0;
      m_phase[i] = 0;
      m_pulse[i] = 1'b0;
      m_err[i]   = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, expressed on integer counts.
  task automatic model_step(input bit s, input bit v, input bit d);
    bit io, id, ovf;
    for (int i = 0; i < 2; i++) begin
      m_pulse[i] = 1'b0;
      if (m_phase[i] != 2) begin
        io  = v && !d;
        id  = v && d;
        ovf = (io && m_orig[i] == m_max[i]) || (id && m_dup[i] == m_max[i]);
        if (STRICT && ((id && m_phase[i] == 0) || (io && m_phase[i] == 1) ||
                       (id && m_dup[i] + 1 > m_orig[i])))
          m_err[i] = 1'b1;
        if (ovf) begin
          m_phase[i] = 2;
        end else begin
          m_orig[i] += int'(io);
          m_dup[i]  += int'(id);
          if (m_phase[i] == 0 && s) begin
            m_phase[i] = 1;
            m_pulse[i] = 1'b1;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, and return
  // shortly after the edge so the caller sees the post-edge outputs.
  task automatic cyc(input bit s, input bit v, input bit d);
    sif_commit    = s;
    commit_valid  = v;
    commit_is_dup = d;
    @(posedge clk);
    model_step(s, v, d);
    #1;
  endtask

  task automatic do_reset();
    sif_commit    = 1'b0;
    commit_valid  = 1'b0;
    commit_is_dup = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pulse8", 32'(p8), 32'(m_pulse[0]));
      chk("qcv8",   32'(q8), 32'(exp_qcv(0)));
      chk("orig8",  32'(o8), 32'(m_orig[0]));
      chk("dup8",   32'(d8), 32'(m_dup[0]));
      chk("err8",   32'(e8), 32'(m_err[0]));
      chk("pulse2", 32'(p2), 32'(m_pulse[1]));
      chk("qcv2",   32'(q2), 32'(exp_qcv(1)));
      chk("orig2",  32'(o2), 32'(m_orig[1]));
      chk("dup2",   32'(d2), 32'(m_dup[1]));
      chk("err2",   32'(e2), 32'(m_err[1]));
    end
  end

  initial begin
    bit seen_sif;
    int n;
    model_reset();
    #3;
    do_reset();
    chk_en = 1'b1;
    chk("rst_qcv",   32'(q8), 32'd0);
    chk("rst_pulse", 32'(p8), 32'd0);
    chk("rst_orig",  32'(o8), 32'd0);

    // Three originals, switch, three duplicates
    repeat (3) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1_pulse_hi", 32'(p8), 32'd1);
    chk("t1_qcv_lo",   32'(q8), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t1_pulse_once", 32'(p8), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t1_qcv_2dup", 32'(q8), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t1_qcv_hi", 32'(q8), 32'd1);
    chk("t1_orig",   32'(o8), 32'd3);
    chk("t1_dup",    32'(d8), 32'd3);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t1_no_repulse", 32'(p8), 32'd0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t1_qcv_drop", 32'(q8), 32'd0);

    // Switch with no originals
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    chk("t2_pulse", 32'(p8), 32'd1);
    chk("t2_qcv",   32'(q8), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("t2_pulse_lo", 32'(p8), 32'd0);
    chk("t2_qcv_lo",   32'(q8), 32'd0);

    // Saturation of the 2-bit instance
    do_reset();
    repeat (4) cyc(1'b0, 1'b1, 1'b0);
    chk("t3_orig_sat", 32'(o2), 32'd3);
    chk("t3_orig8",    32'(o8), 32'd4);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t3_no_pulse_sat", 32'(p2), 32'd0);
    repeat (3) cyc(1'b0, 1'b1, 1'b1);
    chk("t3_dup_frozen", 32'(d2), 32'd0);
    chk("t3_qcv_sat",    32'(q2), 32'd0);
    chk("t3_orig_held",  32'(o2), 32'd3);

    // Duplicate before the switch
    do_reset();
    cyc(1'b0, 1'b1, 1'b1);
    chk("t4_err",   32'(e8), 32'(STRICT));
    chk("t4_dup",   32'(d8), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t4_qcv", 32'(q8), STRICT ? 32'd0 : 32'd1);

    // Asynchronous reset in the duplicate phase with counts 2/1
    do_reset();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t5_orig_pre", 32'(o8), 32'd2);
    chk("t5_dup_pre",  32'(d8), 32'd1);
    commit_valid = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t5_async_orig",  32'(o8), 32'd0);
    chk("t5_async_dup",   32'(d8), 32'd0);
    chk("t5_async_pulse", 32'(p8), 32'd0);
    chk("t5_async_qcv",   32'(q8), 32'd0);
    chk("t5_async_err",   32'(e8), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("t5_pulse_again", 32'(p8), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("t5_qcv", 32'(q8), 32'd1);

    // Randomized epochs
    for (int ep = 0; ep < 30; ep++) begin
      do_reset();
      seen_sif = 1'b0;
      n = $urandom_range(80, 20);
      for (int c = 0; c < n; c++) begin
        bit s, v, d;
        s = ($urandom % 12) == 0;
        v = ($urandom % 4) != 0;
        d = seen_sif ? (($urandom % 6) != 0) : (($urandom % 10) == 0);
        cyc(s, v, d);
        if (s) seen_sif = 1'b1;
      end
    end

    @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_qed_commit_tracker
